// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control sequencer for the 9-bit ISA core.
// Decodes the current instruction word into register addresses and raw
// write/branch requests, then gates those requests by a small machine
// state (IDLE / RUN / LOAD_WAIT / HALT). Loads stall for MEM_LAT extra
// cycles before write-back, and a saturating counter tracks the cycles
// spent executing since the last Start.
module ctrl_sequencer #(
  parameter int RAW     = 4,   // register-address width, 4..6
  parameter int MEM_LAT = 1,   // extra load cycles before write-back, 0..15
  parameter int CW      = 16   // cycle-counter width, 8..32
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [8:0]     Instruction,
  output logic           PCEn,
  output logic           RegWrEn,
  output logic           MemWrEn,
  output logic           LoadInst,
  output logic           ConditionalJump,
  output logic           BranchAbsOrRel,
  output logic [1:0]     BranchConditions,
  output logic [RAW-1:0] RegReadAddrA,
  output logic [RAW-1:0] RegReadAddrB,
  output logic [RAW-1:0] RegWriteAddr,
  output logic           Busy,
  output logic           Done,
  output logic [CW-1:0]  CycleCount
);

  // RC is the implicit accumulator register: the highest register index.
  localparam logic [RAW-1:0] RC = '1;

  // Wait counter is sized for the largest legal latency (15).
  localparam int             WCW      = 4;
  localparam bit             HAS_LAT  = (MEM_LAT > 0);
  localparam logic [WCW-1:0] WC_START = WCW'(HAS_LAT ? MEM_LAT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LOAD_WAIT,
    S_HALT
  } state_t;

  state_t         state;
  logic [WCW-1:0] wc;

  // Raw (ungated) decode of the instruction word.
  logic raw_mem_wr;
  logic raw_load;
  logic raw_br;
  logic raw_reg_wr;
  logic halt_word;
  logic load_stalls;

  // Instruction class decode; these are pure functions of the ROM word.
  always_comb begin
    raw_mem_wr  = (Instruction[8:4] == 5'b11011);
    raw_load    = (Instruction[8:4] == 5'b11010);
    raw_br      = (Instruction[8:5] == 4'b1111);
    halt_word   = (Instruction == 9'h1FF);
    raw_reg_wr  = (Instruction[8:6] != 3'b111) && !raw_mem_wr;
    // A load only leaves RUN when there is latency to wait out.
    load_stalls = raw_load && HAS_LAT;
  end

  // Register address decode; driven in every state so the register file
  // read ports always see the operands of the word on the ROM output.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement leaves it unassigned and infers a latch.
    RegReadAddrA = RAW'(Instruction[1:0]);
    RegReadAddrB = RAW'(Instruction[3:2]);
    RegWriteAddr = RAW'(Instruction[1:0]);
    case (Instruction[8:5])
      // Opcodes 0000..0011 read and write the accumulator.
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        RegReadAddrA = RC;
        RegWriteAddr = RC;
      end
      // 0100: I[4]=0 writes RC (with a 3-bit B index when I[3]=0);
      //       I[4]=1 moves RC into the 4-bit register index I[3:0].
      4'b0100: begin
        if (!Instruction[4]) begin
          RegWriteAddr = RC;
          if (!Instruction[3]) begin
            RegReadAddrB = RAW'(Instruction[2:0]);
          end
        end else begin
          RegReadAddrB = RC;
          RegWriteAddr = RAW'(Instruction[3:0]);
        end
      end
      // 0110 with I[4]=1 pairs RC with a full 4-bit register index.
      4'b0110: begin
        if (Instruction[4]) begin
          RegReadAddrA = RC;
          RegReadAddrB = RAW'(Instruction[3:0]);
        end
      end
      default: ;
    endcase
  end

  assign BranchConditions = Instruction[3:2];

  // State-gated enables: the decode requests only reach the datapath in
  // RUN, or at the final cycle of a load wait for the write-back.
  always_comb begin
    PCEn            = 1'b0;
    RegWrEn         = 1'b0;
    MemWrEn         = 1'b0;
    LoadInst        = 1'b0;
    ConditionalJump = 1'b0;
    Busy            = 1'b0;
    Done            = 1'b0;
    case (state)
      S_RUN: begin
        Busy = 1'b1;
        if (halt_word) begin
          // Hold the PC on the halt word; nothing is written.
        end else if (load_stalls) begin
          // First cycle of a stalled load: select the load path, defer
          // the register write until the data is back.
          LoadInst = 1'b1;
        end else begin
          RegWrEn         = raw_reg_wr;
          MemWrEn         = raw_mem_wr;
          LoadInst        = raw_load;
          ConditionalJump = raw_br;
          PCEn            = 1'b1;
        end
      end
      S_LOAD_WAIT: begin
        Busy     = 1'b1;
        LoadInst = 1'b1;
        if (wc == '0) begin
          RegWrEn = 1'b1;
          PCEn    = 1'b1;
        end
      end
      S_HALT: begin
        Done = 1'b1;
      end
      default: ;
    endcase
    // The abs/rel flag only means something alongside a live branch.
    BranchAbsOrRel = ConditionalJump & Instruction[4];
  end

  // Machine state, load wait counter and saturating cycle counter.
  always_ff @(posedge Clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the values from before this edge, in any order.
    if (Reset) begin
      state      <= S_IDLE;
      wc         <= '0;
      CycleCount <= '0;
    end else begin
      if (Busy && (CycleCount != '1)) begin
        CycleCount <= CycleCount + CW'(1);
      end
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state      <= S_RUN;
            CycleCount <= '0;
          end
        end
        S_RUN: begin
          if (halt_word) begin
            state <= S_HALT;
          end else if (load_stalls) begin
            state <= S_LOAD_WAIT;
            wc    <= WC_START;
          end
        end
        S_LOAD_WAIT: begin
          if (wc == '0) begin
            state <= S_RUN;
          end else begin
            wc <= wc - WCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer. Two instances share the same stimulus:
// dut_a (RAW=4, MEM_LAT=0, CW=8) and dut_b (RAW=6, MEM_LAT=3, CW=16).
// Directed tables and sequences use hand-computed constants; a random
// phase compares both instances against a cycle-level behavioural model.
module tb_ctrl_sequencer;

  localparam int RAW_A = 4;
  localparam int LAT_A = 0;
  localparam int CW_A  = 8;
  localparam int RAW_B = 6;
  localparam int LAT_B = 3;
  localparam int CW_B  = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [8:0] Instruction;

  always #5 Clk = ~Clk;

  logic             PCEn_a, RegWrEn_a, MemWrEn_a, LoadInst_a, CJ_a, BAR_a, Busy_a, Done_a;
  logic [1:0]       BC_a;
  logic [RAW_A-1:0] A_a, B_a, W_a;
  logic [CW_A-1:0]  CC_a;

  logic             PCEn_b, RegWrEn_b, MemWrEn_b, LoadInst_b, CJ_b, BAR_b, Busy_b, Done_b;
  logic [1:0]       BC_b;
  logic [RAW_B-1:0] A_b, B_b, W_b;
  logic [CW_B-1:0]  CC_b;

  ctrl_sequencer #(.RAW(RAW_A), .MEM_LAT(LAT_A), .CW(CW_A)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .PCEn(PCEn_a), .RegWrEn(RegWrEn_a), .MemWrEn(MemWrEn_a), .LoadInst(LoadInst_a),
    .ConditionalJump(CJ_a), .BranchAbsOrRel(BAR_a), .BranchConditions(BC_a),
    .RegReadAddrA(A_a), .RegReadAddrB(B_a), .RegWriteAddr(W_a),
    .Busy(Busy_a), .Done(Done_a), .CycleCount(CC_a)
  );

  ctrl_sequencer #(.RAW(RAW_B), .MEM_LAT(LAT_B), .CW(CW_B)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .PCEn(PCEn_b), .RegWrEn(RegWrEn_b), .MemWrEn(MemWrEn_b), .LoadInst(LoadInst_b),
    .ConditionalJump(CJ_b), .BranchAbsOrRel(BAR_b), .BranchConditions(BC_b),
    .RegReadAddrA(A_b), .RegReadAddrB(B_b), .RegWriteAddr(W_b),
    .Busy(Busy_b), .Done(Done_b), .CycleCount(CC_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output snapshot: flags {busy,done,pc,regwr,memwr,load,cjump,absrel}.
  function automatic logic [63:0] pack(input logic [7:0] f, input logic [1:0] bc,
                                       input int a, input int b, input int w,
                                       input int unsigned cc);
    return {4'h0, f, bc, a[5:0], b[5:0], w[5:0], cc};
  endfunction

  function automatic logic [63:0] act_a(input bit with_cc);
    return pack({Busy_a, Done_a, PCEn_a, RegWrEn_a, MemWrEn_a, LoadInst_a, CJ_a, BAR_a},
                BC_a, int'(A_a), int'(B_a), int'(W_a), with_cc ? 32'(CC_a) : 32'd0);
  endfunction

  function automatic logic [63:0] act_b();
    return pack({Busy_b, Done_b, PCEn_b, RegWrEn_b, MemWrEn_b, LoadInst_b, CJ_b, BAR_b},
                BC_b, int'(A_b), int'(B_b), int'(W_b), 32'(CC_b));
  endfunction

  task automatic to_pos();
    @(posedge Clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    to_pos();
    Reset = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  // phase: idle / executing / halted. age counts the cycles already spent
  // on the current load; a load finishes when age reaches its latency.
  localparam int P_IDLE = 0;
  localparam int P_EXEC = 1;
  localparam int P_HALT = 2;

  typedef struct {
    int          phase;
    int          age;
    int unsigned cc;
  } mstate_t;

  function automatic logic [63:0] model_out(input mstate_t s, input logic [8:0] i,
                                            input int raw, input int lat);
    int   rc = (1 << raw) - 1;
    int   a  = int'(i[1:0]);
    int   b  = int'(i[3:2]);
    int   w  = int'(i[1:0]);
    bit   is_st   = (i[8:4] == 5'h1B);
    bit   is_ld   = (i[8:4] == 5'h1A);
    bit   is_br   = (i[8:5] == 4'hF);
    bit   is_halt = (i == 9'h1FF);
    bit   writes  = (i[8:6] != 3'h7) && !is_st;
    bit   busy = 0, done = 0, pc = 0, rw = 0, mw = 0, ld = 0, cj = 0;
    if (i[8:5] <= 4'd3) begin
      a = rc;
      w = rc;
    end else if (i[8:5] == 4'd4) begin
      if (!i[4]) begin
        w = rc;
        if (!i[3]) b = int'(i[2:0]);
      end else begin
        b = rc;
        w = int'(i[3:0]);
      end
    end else if (i[8:5] == 4'd6 && i[4]) begin
      a = rc;
      b = int'(i[3:0]);
    end
    if (s.phase == P_EXEC) begin
      busy = 1;
      if (is_halt) begin
        pc = 0;
      end else if (is_ld && lat > 0) begin
        ld = 1;
        pc = (s.age == lat);
        rw = (s.age == lat);
      end else begin
        rw = writes;
        mw = is_st;
        ld = is_ld;
        cj = is_br;
        pc = 1;
      end
    end
    done = (s.phase == P_HALT);
    return pack({busy, done, pc, rw, mw, ld, cj, cj & i[4]}, i[3:2], a, b, w, s.cc);
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic start,
                                         input logic [8:0] i, input int lat, input int cw);
    mstate_t     n   = s;
    int unsigned top = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    if (rst) begin
      n.phase = P_IDLE;
      n.age   = 0;
      n.cc    = 0;
    end else if (s.phase == P_EXEC) begin
      if (s.cc != top) n.cc = s.cc + 1;
      if (i == 9'h1FF) n.phase = P_HALT;
      else if (i[8:4] == 5'h1A && lat > 0) n.age = (s.age == lat) ? 0 : s.age + 1;
    end else if (start) begin
      n.phase = P_EXEC;
      n.cc    = 0;
    end
    return n;
  endfunction

  function automatic logic [8:0] rand_instr();
    int r = $urandom_range(0, 99);
    if (r < 25) return {5'b11010, 4'($urandom)};
    if (r < 35) return {5'b11011, 4'($urandom)};
    if (r < 50) return {4'b1111, 5'($urandom)};
    if (r < 53) return 9'h1FF;
    return 9'($urandom);
  endfunction

  // ---------------- decode table (dut_a in RUN, MEM_LAT=0) ----------------
  typedef struct {
    string      name;
    logic [8:0] instr;
    logic [7:0] flags;
    logic [1:0] bc;
    int         a;
    int         b;
    int         w;
  } vec_t;

  vec_t tbl[14];

  localparam logic [8:0] LOAD_WORD = 9'b110100110;

  initial begin
    mstate_t ma, mb;

    tbl[0]  = '{"rc_add",      9'h000,       8'b1011_0000, 2'b00, 15, 0,  15};
    tbl[1]  = '{"op0001",      9'b000110110, 8'b1011_0000, 2'b01, 15, 1,  15};
    tbl[2]  = '{"op0100_b3",   9'b010000101, 8'b1011_0000, 2'b01, 1,  5,  15};
    tbl[3]  = '{"op0100_b2",   9'b010001110, 8'b1011_0000, 2'b11, 2,  3,  15};
    tbl[4]  = '{"op0100_mv",   9'b010011011, 8'b1011_0000, 2'b10, 3,  15, 11};
    tbl[5]  = '{"op0110_rc",   9'b011011001, 8'b1011_0000, 2'b10, 15, 9,  1};
    tbl[6]  = '{"op0110_plain",9'b011000111, 8'b1011_0000, 2'b01, 3,  1,  3};
    tbl[7]  = '{"store",       9'b110110001, 8'b1010_1000, 2'b00, 1,  0,  1};
    tbl[8]  = '{"load_lat0",   LOAD_WORD,    8'b1011_0100, 2'b01, 2,  1,  2};
    tbl[9]  = '{"after_load",  9'b101110010, 8'b1011_0000, 2'b00, 2,  0,  2};
    tbl[10] = '{"branch_rel",  9'b111110100, 8'b1010_0011, 2'b01, 0,  1,  0};
    tbl[11] = '{"branch_abs",  9'b111101011, 8'b1010_0010, 2'b10, 3,  2,  3};
    tbl[12] = '{"op1110",      9'b111001100, 8'b1010_0000, 2'b11, 0,  3,  0};
    tbl[13] = '{"op0011",      9'b001111111, 8'b1011_0000, 2'b11, 15, 3,  15};

    Reset       = 1'b1;
    Start       = 1'b0;
    Instruction = 9'h000;
    to_pos();
    Reset = 1'b0;

    // Reset state: enables low, addresses follow the instruction.
    to_neg();
    check("reset_a", act_a(1), pack(8'h00, 2'b00, 15, 0, 15, 0));
    check("reset_b", act_b(),  pack(8'h00, 2'b00, 63, 0, 63, 0));

    // rc_add after a one-cycle Start; counter counts RUN cycles.
    Start = 1'b1;
    to_pos();
    Start = 1'b0;
    to_neg();
    check("rc_add_first", act_a(1), pack(8'b1011_0000, 2'b00, 15, 0, 15, 0));
    for (int k = 1; k <= 3; k++) begin
      to_pos();
      to_neg();
      check($sformatf("rc_add_cc%0d", k), 64'(CC_a), 64'(k));
    end
    // Start while running is ignored.
    Start = 1'b1;
    to_pos();
    Start = 1'b0;
    to_neg();
    check("start_in_run", {63'(CC_a), Busy_a}, {63'd4, 1'b1});

    // Decode table.
    for (int t = 0; t < 14; t++) begin
      Instruction = tbl[t].instr;
      to_neg();
      check(tbl[t].name, act_a(0), pack(tbl[t].flags, tbl[t].bc, tbl[t].a, tbl[t].b, tbl[t].w, 0));
      to_pos();
    end

    // Load with MEM_LAT=3: three stalled cycles, write-back on the fourth.
    do_reset();
    Start       = 1'b1;
    Instruction = LOAD_WORD;
    to_pos();
    Start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      to_neg();
      check($sformatf("load_lat3_c%0d", c), act_b(),
            pack((c == 3) ? 8'b1011_0100 : 8'b1000_0100, 2'b01, 2, 1, 2, c));
      to_pos();
    end
    Instruction = 9'h000;
    to_neg();
    check("load_lat3_resume", act_b(), pack(8'b1011_0000, 2'b00, 63, 0, 63, 4));

    // Halt after five run cycles, then restart.
    do_reset();
    Start       = 1'b1;
    Instruction = 9'h000;
    to_pos();
    Start = 1'b0;
    repeat (5) to_pos();
    Instruction = 9'h1FF;
    to_neg();
    check("halt_seen", act_b(), pack(8'b1000_0000, 2'b11, 3, 3, 3, 5));
    to_pos();
    to_neg();
    check("halt_done", act_b(), pack(8'b0100_0000, 2'b11, 3, 3, 3, 6));
    repeat (3) to_pos();
    to_neg();
    check("halt_frozen", act_b(), pack(8'b0100_0000, 2'b11, 3, 3, 3, 6));
    to_pos();
    Start = 1'b1;
    to_pos();
    Start       = 1'b0;
    Instruction = 9'h000;
    to_neg();
    check("halt_restart", act_b(), pack(8'b1011_0000, 2'b00, 63, 0, 63, 0));

    // Reset in the second LOAD_WAIT cycle, with Start also high.
    do_reset();
    Start       = 1'b1;
    Instruction = LOAD_WORD;
    to_pos();
    Start = 1'b0;
    to_pos();
    to_pos();
    Reset = 1'b1;
    Start = 1'b1;
    to_neg();
    check("lw2_before_reset", act_b(), pack(8'b1000_0100, 2'b01, 2, 1, 2, 2));
    to_pos();
    Reset = 1'b0;
    Start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      check($sformatf("lw_reset_idle%0d", c), act_b(), pack(8'h00, 2'b01, 2, 1, 2, 0));
      to_pos();
    end

    // Counter saturation with CW=8.
    do_reset();
    Start       = 1'b1;
    Instruction = 9'h000;
    to_pos();
    Start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      to_pos();
      if (c == 254 || c == 255 || c == 256 || c == 300) begin
        check($sformatf("sat_cc_%0d", c), 64'(CC_a), 64'((c > 255) ? 255 : c));
      end
    end

    // Random phase against the behavioural model.
    do_reset();
    ma = '{P_IDLE, 0, 0};
    mb = '{P_IDLE, 0, 0};
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(0, 63) == 0);
      Start = ($urandom_range(0, 5) == 0);
      // The ROM word only changes once the slower instance may fetch.
      if (mb.age == 0) Instruction = rand_instr();
      to_neg();
      check($sformatf("rand_a_%0d", n), act_a(1), model_out(ma, Instruction, RAW_A, LAT_A));
      check($sformatf("rand_b_%0d", n), act_b(),  model_out(mb, Instruction, RAW_B, LAT_B));
      to_pos();
      ma = model_next(ma, Reset, Start, Instruction, LAT_A, CW_A);
      mb = model_next(mb, Reset, Start, Instruction, LAT_B, CW_B);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
